sha2_k_sequencer: RTL and testbench
===================================

# sha2_k_sequencer

Self-sequencing SHA-2 round-constant source with run-time SHA-256/SHA-512 selection. It holds the K table internally, steps the round index itself once started, and presents one registered constant per accepted cycle with valid/last/done flags. It sits beside the message scheduler and compression datapath and replaces the externally-indexed K lookup. The core's control FSM issues `start` and applies `hold` whenever the round datapath stalls.

## Interface
- `K_W`, 64, output constant width; legal values 32 or 64. With 32, SHA-512 mode is unavailable.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a constant sequence; sampled only in IDLE.
- `mode`  in  1  0 = SHA-256 (64 rounds), 1 = SHA-512 (80 rounds); latched on accepted `start`.
- `hold`  in  1  stall; freezes index and outputs while high.
- `abort`  in  1  synchronous cancel of a running sequence.
- `k_valid`  out  1  `k_out`/`round_out` hold a valid constant.
- `k_out`  out  K_W  round constant.
- `round_out`  out  7  index of the constant on `k_out`.
- `k_last`  out  1  high with the final constant (round 63 or 79).
- `busy`  out  1  FSM not in IDLE.
- `done`  out  1  one-cycle pulse after the last constant is accepted.

## Operation
- Single table: 80 entries of 64-bit SHA-512 K. The SHA-256 K[i] is bits [63:32] of SHA-512 K[i], for i = 0..63.
- Output format:
  - Mode 0: `k_out` = zero-extended 32-bit K256[r].
  - Mode 1: `k_out` = K512[r].
  - `K_W`=32: `k_out` = K256[r].
- FSM states:
  - IDLE: `start`=1 latches `mode`, sets r=0, goes to RUN.
  - RUN: each cycle with `hold`=0 the current constant is consumed and r increments. When the constant with r=N-1 is consumed (N = 64 or 80), go to DONE.
  - DONE: `done`=1 for one cycle, then IDLE unconditionally.
- Priority in RUN: `abort` > `hold` > advance. `abort` returns to IDLE next cycle with `k_valid`=0, `k_last`=0, and no `done`.
- Ignored inputs:
  - `start` in RUN or DONE.
  - `hold` and `abort` in IDLE or DONE.
- `mode`=1 with `K_W`=32 or with the macro absent is treated as mode 0.
- `round_out` never exceeds N-1. The index does not wrap; termination is via DONE.
- A new `start` is accepted in the first IDLE cycle after DONE, so the minimum gap between sequences is 1 cycle.

## Timing
- All outputs are registered.
- Reset values: `k_valid`=0, `k_out`=0, `round_out`=0, `k_last`=0, `busy`=0, `done`=0; FSM in IDLE.
- Start latency: `start` sampled at edge t gives `k_valid`=1, `round_out`=0, and K[0] after edge t. `busy`=1 from the same edge.
- Throughput: one constant per cycle while `hold`=0. A constant is consumed on an edge where `k_valid`=1 and `hold`=0.
- `hold` at edge t keeps `k_out`, `round_out` and `k_last` unchanged after t.
- Last constant: `k_last`=1 exactly while `round_out`=N-1. When it is consumed, the next cycle has `k_valid`=0, `k_last`=0, `done`=1, `busy`=1. The cycle after that has `busy`=0.
- Reset assertion mid-run forces all outputs to their reset values immediately (asynchronous) and discards the sequence.

## Configuration
- `SHA2_K512_EN` defined:
  - 80×64 table compiled in.
  - `mode` honoured when `K_W`=64.
- `SHA2_K512_EN` undefined:
  - Only the 64×32 SHA-256 table is compiled.
  - `mode` is ignored and every sequence is 64 rounds.
  - `k_out` upper bits are zero when `K_W`=64.

## Test plan
- SHA-256 sweep: reset release, `start`=1 with `mode`=0, `hold`=0 → 64 consecutive valid cycles.
  - K[0]=0x428a2f98, K[10]=0x243185be, K[63]=0xc67178f2.
  - `k_last` only at round 63; `done` one cycle later; `busy` low the cycle after.
- SHA-512 sweep (macro on, `K_W`=64): `start` with `mode`=1 → 80 valid cycles.
  - K[0]=0x428a2f98d728ae22, K[79]=0x6c44198c4a475817, `k_last` at round 79.
- Hold: mode 0, `hold` high for 3 cycles while `round_out`=11 → `k_out` stays 0x550c7dc3 for 4 cycles, then round 12 = 0x72be5d74. Total run length is 67 cycles.
- Ignored `start` and abort:
  - `start` pulsed at round 20 → no effect; sequence ends at round 63.
  - `abort` at round 5 → IDLE next cycle, `k_valid`=0, no `done`.
  - Immediate restart after abort → round 0 = 0x428a2f98.
- Reset mid-run: `reset` driven low at round 30 → all outputs 0 within the same cycle, not waiting for an edge. After release the block stays idle until `start`.
- Macro off: `start` with `mode`=1 → 64 rounds, K[0]=0x00000000428a2f98 with `K_W`=64.

Source files
------------

// File: rtl/sha2_k_sequencer_if.sv
// sha2_k_sequencer_if: control/constant bundle between the core control FSM
// (master) and the self-sequencing SHA-2 round-constant source (slave).
//   start/mode/hold/abort : master -> slave control
//   k_valid/k_out/round_out/k_last/busy/done : slave -> master status/data
interface sha2_k_sequencer_if #(
  parameter int unsigned K_W = 64
);
  logic           start;
  logic           mode;
  logic           hold;
  logic           abort;
  logic           k_valid;
  logic [K_W-1:0] k_out;
  logic [6:0]     round_out;
  logic           k_last;
  logic           busy;
  logic           done;

  modport master (
    output start, mode, hold, abort,
    input  k_valid, k_out, round_out, k_last, busy, done
  );

  modport slave (
    input  start, mode, hold, abort,
    output k_valid, k_out, round_out, k_last, busy, done
  );
endinterface

// File: rtl/sha2_k_sequencer.sv
// sha2_k_sequencer: self-sequencing SHA-2 round-constant source.
// After an accepted start it walks the round index on its own and presents one
// registered constant per non-held cycle, flagging the final constant with
// k_last and pulsing done once that constant has been consumed.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : sha2_k_sequencer_if.slave (start, mode, hold, abort in;
//           k_valid, k_out, round_out, k_last, busy, done out, all registered)
// Build option: define SHA2_K512_EN to compile the 80x64 SHA-512 table and
// honour mode=1 when K_W=64; otherwise only the 64x32 SHA-256 table exists and
// every sequence is 64 rounds.
module sha2_k_sequencer #(
  parameter int unsigned K_W = 64
) (
  input logic               clk,
  input logic               reset,
  sha2_k_sequencer_if.slave bus
);

  localparam int unsigned      RND_W    = 7;
  localparam logic [RND_W-1:0] LAST_256 = 7'd63;
  localparam logic [RND_W-1:0] LAST_512 = 7'd79;

`ifdef SHA2_K512_EN
  localparam bit K512_OK = (K_W == 64);
  // SHA-512 K; the SHA-256 constants are the upper 32 bits of entries 0..63.
  localparam logic [63:0] K512_TAB [80] = '{
    64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
    64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
    64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
    64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
    64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
    64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
    64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
    64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
    64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
    64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
    64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
    64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
    64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
    64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
    64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
    64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
    64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
    64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
    64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
    64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
  };
`else
  localparam bit K512_OK = 1'b0;
  localparam logic [31:0] K256_TAB [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             mode512_q, mode512_d;
  logic             k_valid_q, k_valid_d;
  logic [K_W-1:0]   k_out_q, k_out_d;
  logic [RND_W-1:0] round_q, round_d;
  logic             k_last_q, k_last_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [RND_W-1:0] last_idx_c;
  logic [RND_W-1:0] idx_c;
  logic             mode_sel_c;
  logic [K_W-1:0]   k_lookup_c;

  // Index and mode of the constant that would be loaded on the next edge.
  // The index saturates at the final round so the table is never over-read.
  always_comb begin
    last_idx_c = mode512_q ? LAST_512 : LAST_256;
    if (state_q == S_IDLE) begin
      mode_sel_c = bus.mode & K512_OK;
      idx_c      = '0;
    end else begin
      mode_sel_c = mode512_q;
      idx_c      = (round_q == last_idx_c) ? round_q : round_q + 7'd1;
    end
  end

  // Table read and output formatting.
`ifdef SHA2_K512_EN
  logic [63:0] k_ent_c;
  always_comb begin
    k_ent_c    = K512_TAB[idx_c];
    k_lookup_c = mode_sel_c ? K_W'(k_ent_c) : K_W'(k_ent_c[63:32]);
  end
`else
  logic unused_c;
  always_comb begin
    k_lookup_c = K_W'(K256_TAB[idx_c[5:0]]);
  end
  assign unused_c = ^{idx_c[6], mode_sel_c};
`endif

  // Next-state and registered-output logic; abort outranks hold in RUN.
  always_comb begin
    state_d   = state_q;
    mode512_d = mode512_q;
    k_valid_d = k_valid_q;
    k_out_d   = k_out_q;
    round_d   = round_q;
    k_last_d  = k_last_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d   = S_RUN;
          mode512_d = mode_sel_c;
          k_valid_d = 1'b1;
          k_out_d   = k_lookup_c;
          round_d   = '0;
          k_last_d  = 1'b0;
          busy_d    = 1'b1;
        end
      end
      S_RUN: begin
        if (bus.abort) begin
          state_d   = S_IDLE;
          k_valid_d = 1'b0;
          k_out_d   = '0;
          round_d   = '0;
          k_last_d  = 1'b0;
          busy_d    = 1'b0;
        end else if (!bus.hold) begin
          if (round_q == last_idx_c) begin
            state_d   = S_DONE;
            k_valid_d = 1'b0;
            k_out_d   = '0;
            round_d   = '0;
            k_last_d  = 1'b0;
            done_d    = 1'b1;
          end else begin
            round_d  = idx_c;
            k_out_d  = k_lookup_c;
            k_last_d = (idx_c == last_idx_c);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d   = S_IDLE;
        k_valid_d = 1'b0;
        k_last_d  = 1'b0;
        busy_d    = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      mode512_q <= 1'b0;
      k_valid_q <= 1'b0;
      k_out_q   <= '0;
      round_q   <= '0;
      k_last_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode512_q <= mode512_d;
      k_valid_q <= k_valid_d;
      k_out_q   <= k_out_d;
      round_q   <= round_d;
      k_last_q  <= k_last_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.k_valid   = k_valid_q;
  assign bus.k_out     = k_out_q;
  assign bus.round_out = round_q;
  assign bus.k_last    = k_last_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_sha2_k_sequencer.sv
// tb_sha2_k_sequencer: scoreboard bench for sha2_k_sequencer. Each started
// sequence pushes its expected (round, constant, last) entries; entries are
// popped and compared on every cycle a constant is consumed.
module tb_sha2_k_sequencer;

  localparam int unsigned K_W = 64;
`ifdef SHA2_K512_EN
  localparam bit K512_ON = 1'b1;
`else
  localparam bit K512_ON = 1'b0;
`endif

  typedef struct packed {
    logic [6:0]  rnd;
    logic [63:0] k;
    logic        last;
  } exp_t;

  localparam logic [63:0] KREF [80] = '{
    64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
    64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
    64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
    64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
    64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
    64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
    64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
    64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
    64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
    64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
    64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
    64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
    64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
    64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
    64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
    64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
    64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
    64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
    64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
    64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
  };

  logic clk = 1'b0;
  logic reset;
  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  sha2_k_sequencer_if #(.K_W(K_W)) bus ();

  sha2_k_sequencer #(.K_W(K_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_k_valid"}, 64'(bus.k_valid), 64'd0);
    check_val({tag, "_k_out"}, 64'(bus.k_out), 64'd0);
    check_val({tag, "_round"}, 64'(bus.round_out), 64'd0);
    check_val({tag, "_k_last"}, 64'(bus.k_last), 64'd0);
    check_val({tag, "_busy"}, 64'(bus.busy), 64'd0);
    check_val({tag, "_done"}, 64'(bus.done), 64'd0);
  endtask

  // One sequence: optional hold window, ignored start pulse, or abort at a round.
  task automatic run_seq(input bit m, input int hold_r, input int hold_n,
                         input int start_r, input int abort_r);
    bit   m_eff;
    int   n;
    int   held;
    int   valid_cycles;
    bit   hold_prev;
    bit   finished;
    bit   ab;
    exp_t snap;
    exp_t e;
    m_eff = m && K512_ON;
    n     = m_eff ? 80 : 64;
    sb_q.delete();
    for (int r = 0; r < n; r++) begin
      e.rnd  = 7'(r);
      e.k    = m_eff ? KREF[r] : {32'h0, KREF[r][63:32]};
      e.last = (r == n - 1);
      sb_q.push_back(e);
    end
    bus.start = 1'b1;
    bus.mode  = m;
    step();
    bus.start = 1'b0;
    bus.mode  = 1'b0;
    check_val("start_valid", 64'(bus.k_valid), 64'd1);
    check_val("start_busy", 64'(bus.busy), 64'd1);
    held         = 0;
    valid_cycles = 0;
    hold_prev    = 1'b0;
    finished     = 1'b0;
    snap         = '0;
    for (int cyc = 0; cyc < 200 && !finished; cyc++) begin
      if (hold_prev) begin
        check_val("hold_k", bus.k_out, snap.k);
        check_val("hold_round", 64'(bus.round_out), 64'(snap.rnd));
        check_val("hold_last", 64'(bus.k_last), 64'(snap.last));
      end
      hold_prev = 1'b0;
      if (bus.done) begin
        check_val("done_valid", 64'(bus.k_valid), 64'd0);
        check_val("done_busy", 64'(bus.busy), 64'd1);
        check_val("done_last", 64'(bus.k_last), 64'd0);
        check_val("sb_empty", 64'(sb_q.size()), 64'd0);
        check_val("run_len", 64'(valid_cycles), 64'(n + hold_n));
        step();
        check_val("done_pulse", 64'(bus.done), 64'd0);
        check_val("idle_busy", 64'(bus.busy), 64'd0);
        finished = 1'b1;
      end else if (bus.k_valid) begin
        valid_cycles++;
        bus.abort = (int'(bus.round_out) == abort_r);
        bus.start = (int'(bus.round_out) == start_r);
        bus.hold  = (int'(bus.round_out) == hold_r) && (held < hold_n);
        ab        = bus.abort;
        hold_prev = bus.hold && !bus.abort;
        if (bus.hold) held++;
        snap = '{rnd: bus.round_out, k: bus.k_out, last: bus.k_last};
        if (!bus.hold && !bus.abort) begin
          check_val("sb_nonempty", 64'(sb_q.size() > 0), 64'd1);
          if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_val("round", 64'(bus.round_out), 64'(e.rnd));
            check_val("k", bus.k_out, e.k);
            check_val("last", 64'(bus.k_last), 64'(e.last));
          end
        end
        step();
        bus.abort = 1'b0;
        bus.start = 1'b0;
        bus.hold  = 1'b0;
        if (ab) begin
          check_val("abort_valid", 64'(bus.k_valid), 64'd0);
          check_val("abort_last", 64'(bus.k_last), 64'd0);
          check_val("abort_done", 64'(bus.done), 64'd0);
          check_val("abort_busy", 64'(bus.busy), 64'd0);
          step();
          check_val("abort_no_done", 64'(bus.done), 64'd0);
          check_val("abort_idle", 64'(bus.k_valid), 64'd0);
          finished = 1'b1;
        end
      end else begin
        check_val("unexpected_gap", 64'(bus.k_valid), 64'd1);
        finished = 1'b1;
      end
    end
    check_val("seq_timeout", 64'(finished), 64'd1);
  endtask

  // Asynchronous reset in the middle of a run, away from any clock edge.
  task automatic reset_mid_run();
    bus.start = 1'b1;
    bus.mode  = 1'b0;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 30; i++) step();
    check_val("pre_reset_round", 64'(bus.round_out), 64'd30);
    check_val("pre_reset_k", bus.k_out, {32'h0, KREF[30][63:32]});
    #2;
    reset = 1'b0;
    #1;
    check_all_zero("async_rst");
    reset = 1'b1;
    for (int i = 0; i < 3; i++) step();
    check_all_zero("post_rst_idle");
  endtask

  initial begin
    reset     = 1'b0;
    bus.start = 1'b0;
    bus.mode  = 1'b0;
    bus.hold  = 1'b0;
    bus.abort = 1'b0;
    step();
    step();
    check_all_zero("reset");
    reset = 1'b1;
    step();
    // hold/abort while idle must do nothing
    bus.hold  = 1'b1;
    bus.abort = 1'b1;
    step();
    step();
    bus.hold  = 1'b0;
    bus.abort = 1'b0;
    check_all_zero("idle_ignore");

    run_seq(1'b0, -1, 0, -1, -1);
    run_seq(1'b0, 11, 3, -1, -1);
    run_seq(1'b0, -1, 0, 20, -1);
    run_seq(1'b0, -1, 0, -1, 5);
    run_seq(1'b0, -1, 0, -1, -1);
    run_seq(1'b1, -1, 0, -1, -1);
    run_seq(1'b1, 40, 2, -1, -1);
    reset_mid_run();
    run_seq(1'b0, -1, 0, -1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
